// File: rtl/mod_counter_ctrl.sv
// Modulo-N up/down counter with IDLE/RUN/HALT control; count and tc are registered (one edge after the sampled inputs).
// No backpressure: start/stop/load/clear are sampled every edge with priority clear > load > start > stop > count.
module mod_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14,
  parameter bit ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tc
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter_ctrl: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Largest legal count; fits in WIDTH bits even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             load_over;

  assign load_over = ({1'b0, load_val} >= (WIDTH + 1)'(MODULUS));
  assign running   = (state_q == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      tc      <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    tc_d    = 1'b0;
    if (!clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = load_over ? LAST : load_val;
    end else begin
      if (start) begin
        state_d = RUN;
      end else if (stop && state_q == RUN) begin
        state_d = HALT;
      end
      // Stepping follows the pre-edge state, so the start edge never steps.
      if (state_q == RUN) begin
        if (!dir) begin
          if (count == LAST) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            count_d = LAST;
            tc_d    = 1'b1;
          end else begin
            count_d = count - 1'b1;
          end
        end
        if (tc_d && ONESHOT && !start) begin
          state_d = HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Bench for mod_counter_ctrl: three instances (14 free-run, 14 one-shot, 16 free-run) share stimulus.
module tb_mod_counter_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       dir;
  logic [3:0] cnt [3];
  logic       run [3];
  logic       tcs [3];

  int errors = 0;
  int checks = 0;

  int mods [3] = '{14, 14, 16};
  bit osh  [3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt [3];
  bit m_run [3];
  bit m_tc  [3];

  mod_counter_ctrl #(.WIDTH(4), .MODULUS(14), .ONESHOT(1'b0)) u_free (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir),
    .count(cnt[0]), .running(run[0]), .tc(tcs[0]));

  mod_counter_ctrl #(.WIDTH(4), .MODULUS(14), .ONESHOT(1'b1)) u_oneshot (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir),
    .count(cnt[1]), .running(run[1]), .tc(tcs[1]));

  mod_counter_ctrl #(.WIDTH(4), .MODULUS(16), .ONESHOT(1'b0)) u_full (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir),
    .count(cnt[2]), .running(run[2]), .tc(tcs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: count is an integer modulo m, running is a single flag.
  task automatic model_step(input int i);
    int  m;
    bit  wrap;
    bit  nrun;
    m    = mods[i];
    wrap = 1'b0;
    if (!clear) begin
      m_cnt[i] = 0;
      m_run[i] = 1'b0;
      m_tc[i]  = 1'b0;
    end else if (load) begin
      m_cnt[i] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
      m_tc[i]  = 1'b0;
    end else begin
      nrun = m_run[i];
      if (start) nrun = 1'b1;
      else if (stop) nrun = 1'b0;
      if (m_run[i]) begin
        if (!dir) begin
          wrap     = (m_cnt[i] + 1 == m);
          m_cnt[i] = (m_cnt[i] + 1) % m;
        end else begin
          wrap     = (m_cnt[i] == 0);
          m_cnt[i] = (m_cnt[i] + m - 1) % m;
        end
        if (wrap && osh[i] && !start) nrun = 1'b0;
      end
      m_tc[i]  = wrap;
      m_run[i] = nrun;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_run[i] = 1'b0;
      m_tc[i]  = 1'b0;
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; clear = 1'b1; load = 1'b0; load_val = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    dir = 1'b0;
    reset = 1'b1;
    model_reset();
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic load_value(input logic [3:0] v);
    load_val = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    dir = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 4'd0 || run[i] !== 1'b0 || tcs[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: count=%0d running=%b tc=%b expected 0/0/0", i, cnt[i], run[i], tcs[i]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_count_up();
    logic [3:0] ec;
    do_reset();
    pulse_start();
    checks++;
    if (run[0] !== 1'b1 || cnt[0] !== 4'd0) begin
      errors++;
      $display("FAIL up_start: running=%b count=%0d expected 1/0", run[0], cnt[0]);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      ec = 4'(k % 14);
      checks++;
      if (cnt[0] !== ec || tcs[0] !== (k == 14)) begin
        errors++;
        $display("FAIL up_seq step%0d: count=%0d tc=%b expected %0d/%b", k, cnt[0], tcs[0], ec, (k == 14));
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd1, 4'd0, 4'd13, 4'd12};
    do_reset();
    dir = 1'b1;
    load_value(4'd2);
    pulse_start();
    checks++;
    if (cnt[0] !== 4'd2 || run[0] !== 1'b1) begin
      errors++;
      $display("FAIL down_start: count=%0d running=%b expected 2/1", cnt[0], run[0]);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (cnt[0] !== exp_seq[k] || tcs[0] !== (k == 2)) begin
        errors++;
        $display("FAIL down_seq step%0d: count=%0d tc=%b expected %0d/%b", k, cnt[0], tcs[0], exp_seq[k], (k == 2));
      end
    end
    dir = 1'b0;
  endtask

  task automatic test_start_stop();
    do_reset();
    load_value(4'd5);
    pulse_start();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (run[0] !== 1'b1 || cnt[0] !== 4'd6) begin
      errors++;
      $display("FAIL start_and_stop: running=%b count=%0d expected 1/6", run[0], cnt[0]);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (run[0] !== 1'b0 || cnt[0] !== 4'd8) begin
      errors++;
      $display("FAIL stop_alone: running=%b count=%0d expected 0/8", run[0], cnt[0]);
    end
    tick();
    checks++;
    if (cnt[0] !== 4'd8) begin
      errors++;
      $display("FAIL halt_hold: count=%0d expected 8", cnt[0]);
    end
    pulse_start();
    tick();
    checks++;
    if (run[0] !== 1'b1 || cnt[0] !== 4'd9) begin
      errors++;
      $display("FAIL resume: running=%b count=%0d expected 1/9", run[0], cnt[0]);
    end
  endtask

  task automatic test_load_clear();
    do_reset();
    load_value(4'd15);
    checks++;
    if (cnt[0] !== 4'd13 || cnt[2] !== 4'd15) begin
      errors++;
      $display("FAIL load_sat: count14=%0d count16=%0d expected 13/15", cnt[0], cnt[2]);
    end
    load_value(4'd9);
    pulse_start();
    clear = 1'b0;
    tick();
    checks++;
    if (cnt[0] !== 4'd0 || run[0] !== 1'b0 || tcs[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_run: count=%0d running=%b tc=%b expected 0/0/0", cnt[0], run[0], tcs[0]);
    end
    load_val = 4'd7; load = 1'b1;
    tick();
    load = 1'b0; clear = 1'b1;
    checks++;
    if (cnt[0] !== 4'd0) begin
      errors++;
      $display("FAIL clear_over_load: count=%0d expected 0", cnt[0]);
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] ec;
    do_reset();
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      tick();
      ec = (k < 14) ? 4'(k) : 4'd0;
      checks++;
      if (cnt[1] !== ec || tcs[1] !== (k == 14) || run[1] !== (k < 14)) begin
        errors++;
        $display("FAIL oneshot step%0d: count=%0d tc=%b running=%b expected %0d/%b/%b",
                 k, cnt[1], tcs[1], run[1], ec, (k == 14), (k < 14));
      end
    end
  endtask

  task automatic test_async_reset_full();
    logic [3:0] ec;
    do_reset();
    load_value(4'd10);
    pulse_start();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (cnt[2] !== 4'd0 || run[2] !== 1'b0 || tcs[2] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d running=%b tc=%b expected 0/0/0", cnt[2], run[2], tcs[2]);
    end
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (run[2] !== 1'b0 || cnt[2] !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_idle: running=%b count=%0d expected 0/0", run[2], cnt[2]);
    end
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      tick();
      ec = 4'(k % 16);
      checks++;
      if (cnt[2] !== ec || tcs[2] !== (k == 16)) begin
        errors++;
        $display("FAIL full_range step%0d: count=%0d tc=%b expected %0d/%b", k, cnt[2], tcs[2], ec, (k == 16));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      clear    = ($urandom_range(0, 24) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom_range(0, 15));
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (int'(cnt[i]) !== m_cnt[i] || run[i] !== m_run[i] || tcs[i] !== m_tc[i]) begin
          errors++;
          $display("FAIL random cyc%0d inst%0d: count=%0d running=%b tc=%b expected %0d/%b/%b",
                   n, i, cnt[i], run[i], tcs[i], m_cnt[i], m_run[i], m_tc[i]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    dir   = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_start_stop();
    test_load_clear();
    test_oneshot();
    test_async_reset_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
